// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit/receive blocks.
//   uart_tx_state_t            - transmit frame FSM state encoding
//   UART_DEFAULT_CLKS_PER_BIT  - 100 MHz system clock / 115200 baud
//   UART_DATA_BITS             - data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer shared by the UART TX and RX sides.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   enable    in   count while high, hold while low
//   clear     in   synchronous restart of the bit period (wins over enable)
//   bit_tick  out  high in the last cycle of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // The tick is gated by enable so a parked counter never signals a period end.
  assign bit_tick = enable && (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit LSB-first UART transmit serializer with optional even parity
// and one or two stop bits.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset (aborts any frame in flight)
//   tx_data   in   byte to send, sampled only in the accept cycle
//   tx_valid  in   byte offer, may be a single-cycle pulse
//   tx_ready  out  combinational: idle and no byte currently offered
//   txd       out  registered serial line, idle high
//   tx_busy   out  registered, high while a frame is in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      txd,
  output logic                      tx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_nxt;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [2:0]                bit_cnt, bit_cnt_nxt;
  logic                      stop_cnt, stop_cnt_nxt;
  logic                      parity_bit, parity_nxt;
  logic                      txd_nxt;
  logic                      accept;
  logic                      bit_tick;

  // Ready drops in the same cycle a byte is offered so a registered upstream
  // stage never pops a second byte against a stale ready.
  assign tx_ready = (state == IDLE) && !tx_valid;
  assign accept   = (state == IDLE) && tx_valid;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state != IDLE),
    .clear    (accept),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    parity_nxt   = parity_bit;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_nxt    = tx_data;
          parity_nxt   = ^tx_data;
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
          state_nxt    = START;
        end
      end
      START: begin
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_nxt = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_nxt = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          if ((STOP_BITS == 2) && !stop_cnt) begin
            stop_cnt_nxt = 1'b1;
          end else begin
            stop_cnt_nxt = 1'b0;
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The line level is derived from the next state so the registered pin
    // changes on the same edge as the state, one edge after the accept cycle.
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      PARITY:  txd_nxt = parity_nxt;
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      parity_bit <= parity_nxt;
      txd        <= txd_nxt;
      tx_busy    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. A main instance (4 clocks per
// bit, no parity, one stop bit) is checked frame by frame against a queue of
// expected frames; two side instances share its inputs and exercise parity
// and two stop bits.
module tb_uart_tx;

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] frame;
    logic [7:0] lat;
  } vec_t;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       tb_valid    = 1'b0;
  logic [7:0] tb_data     = 8'h00;
  logic       drain_go    = 1'b0;
  logic       drain_valid = 1'b0;
  logic [7:0] drain_data  = 8'h00;
  int         rd_ptr      = 0;
  logic [7:0] fifo_mem [3];

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, txd, tx_busy;
  logic       ready_par, txd_par, busy_par;
  logic       ready_s2, txd_s2, busy_s2;

  int         n_vectors     = 0;
  int         n_miscompares = 0;
  logic [9:0] exp_q [$];
  logic       mon_active    = 1'b0;
  logic [9:0] mon_frame;
  int         mon_bad;
  bit         mon_abort;

  vec_t       vecs [4];

  always #5 clk = ~clk;

  assign tx_valid = drain_go ? drain_valid : tb_valid;
  assign tx_data  = drain_go ? drain_data  : tb_data;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy)
  );

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut_par (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_par), .txd(txd_par), .tx_busy(busy_par)
  );

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_s2), .txd(txd_s2), .tx_busy(busy_s2)
  );

  // Model of the reply-FIFO drain stage: a registered pop whenever the
  // transmitter advertised ready at the previous edge.
  always @(posedge clk) begin
    if (!drain_go) begin
      drain_valid <= 1'b0;
    end else if (tx_ready && (rd_ptr < 3)) begin
      drain_valid <= 1'b1;
      drain_data  <= fifo_mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end else begin
      drain_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic driveCycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for a single cycle and queue the frame the main instance
  // must produce; ends one cycle after the accept cycle.
  task automatic applyStimulus(input logic [7:0] d, input logic [9:0] fr);
    driveCycle();
    tb_data  = d;
    tb_valid = 1'b1;
    exp_q.push_back(fr);
    @(negedge clk);
    check("ready_drops_on_offer", tx_ready, 1'b0);
    driveCycle();
    tb_valid = 1'b0;
    tb_data  = ~d;
  endtask

  // Start-bit timing and the cycle count until ready returns.
  task automatic checkOutput(input string name, input int exp_lat);
    int lat;
    @(negedge clk);
    check({name, "_start_txd"}, txd, 1'b0);
    check({name, "_start_busy"}, tx_busy, 1'b1);
    lat = 1;
    while (!tx_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_ready_latency"}, lat, exp_lat);
    check({name, "_end_busy"}, tx_busy, 1'b0);
    check({name, "_end_txd"}, txd, 1'b1);
  endtask

  // Frame monitor for the main instance: every cycle of each frame is
  // compared against the expected bit; a reset inside a frame discards it.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_vectors++;
          n_miscompares++;
          $display("[TB] FAIL unexpected_frame: got a start bit, expected idle line");
          repeat (39) @(negedge clk);
        end else begin
          mon_active = 1'b1;
          mon_frame  = exp_q.pop_front();
          mon_bad    = 0;
          mon_abort  = 1'b0;
          for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) begin
              mon_abort = 1'b1;
              break;
            end
            if (txd !== mon_frame[k/4]) mon_bad++;
          end
          if (!mon_abort) begin
            n_vectors++;
            if (mon_bad != 0) begin
              n_miscompares++;
              $display("[TB] FAIL frame: got %0d wrong cycles, expected 0 for frame %b", mon_bad, mon_frame);
            end
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int bad, lows, highs, viol, cyc;
    bit done;
    logic par_sample;

    vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0, lat: 8'd41};
    vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0, lat: 8'd41};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0, lat: 8'd41};
    vecs[3] = '{data: 8'h96, frame: 10'b1_10010110_0, lat: 8'd41};
    fifo_mem[0] = 8'h01;
    fifo_mem[1] = 8'h02;
    fifo_mem[2] = 8'h03;

    // Reset values
    repeat (3) driveCycle();
    @(negedge clk);
    check("reset_txd", txd, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_ready", tx_ready, 1'b1);
    driveCycle();
    rst_n = 1'b1;

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].data, vecs[i].frame);
      checkOutput($sformatf("vec%0d", i), int'(vecs[i].lat));
    end

    // Even parity on 0x07: parity bit 1, 44-cycle frame
    applyStimulus(8'h07, 10'b1_00000111_0);
    bad = 0;
    par_sample = 1'b0;
    for (int k = 0; k < 44; k++) begin
      logic [10:0] pat;
      pat = 11'b1_1_00000111_0;
      @(negedge clk);
      if (txd_par !== pat[k/4]) bad++;
      if (k == 38) par_sample = txd_par;
    end
    check("parity_frame_cycles", bad, 0);
    check("parity_bit", par_sample, 1'b1);
    check("parity_busy_last", busy_par, 1'b1);
    @(negedge clk);
    check("parity_busy_end", busy_par, 1'b0);
    repeat (10) @(negedge clk);

    // Two stop bits on 0x00: 36 low cycles then 8 high cycles
    applyStimulus(8'h00, 10'b1_00000000_0);
    lows  = 0;
    highs = 0;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k < 36 && txd_s2 === 1'b0) lows++;
      if (k >= 36 && txd_s2 === 1'b1) highs++;
    end
    check("stop2_low_cycles", lows, 36);
    check("stop2_high_cycles", highs, 8);
    check("stop2_busy_last", busy_s2, 1'b1);
    @(negedge clk);
    check("stop2_busy_end", busy_s2, 1'b0);
    repeat (10) @(negedge clk);

    // Drain-stage coupling: three bytes in order, ready never high with valid
    exp_q.push_back(10'b1_00000001_0);
    exp_q.push_back(10'b1_00000010_0);
    exp_q.push_back(10'b1_00000011_0);
    driveCycle();
    drain_go = 1'b1;
    viol = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (tx_valid && tx_ready) viol++;
      if (rd_ptr == 3 && exp_q.size() == 0 && !mon_active && tx_ready) done = 1'b1;
    end
    check("drain_done", done, 1'b1);
    check("drain_ready_while_valid", viol, 0);
    check("drain_pops", rd_ptr, 3);
    driveCycle();
    drain_go = 1'b0;
    repeat (10) @(negedge clk);

    // Busy ignore: 0xFF offered during the data bits of 0x55
    applyStimulus(8'h55, 10'b1_01010101_0);
    repeat (9) @(negedge clk);
    driveCycle();
    tb_data  = 8'hFF;
    tb_valid = 1'b1;
    @(negedge clk);
    check("busy_ready_low", tx_ready, 1'b0);
    check("busy_busy_high", tx_busy, 1'b1);
    driveCycle();
    tb_valid = 1'b0;
    cyc = 0;
    while (!tx_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("busy_ignore_no_frame", lows, 0);

    // Reset during data bit 3 of 0x3C, then a clean 0x81
    applyStimulus(8'h3C, 10'b1_00111100_0);
    repeat (16) driveCycle();
    rst_n = 1'b0;
    driveCycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_txd", txd, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    check("abort_ready", tx_ready, 1'b1);
    applyStimulus(8'h81, 10'b1_10000001_0);
    checkOutput("after_abort", 41);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
